// File: rtl/matrix_cpu_core.sv
// matrix_cpu_core: multi-step 8-bit CPU with program/data RAM, LD/STR,
// CALL/RET, vectored per-key interrupts, key auto-repeat and row scanner.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   step_en, run     CPU advances one step when both are high
//   key_in           raw keys, synchronised inside
//   prog_we/addr/data  RAM write port (wins over STR)
//   view             1: matrix shows R0..R7, 0: VR0..VR7
//   col, row         column data, active-low one-hot row select
//   r6_out, c_flag, ie  R6 contents, carry flag, interrupt enable
module matrix_cpu_core #(
   parameter int RAM_AW   = 8,
   parameter int NUM_KEYS = 6,
   parameter int REP_DLY  = 24,
   parameter int REP_RATE = 8,
   parameter int SCAN_DIV = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                step_en,
   input  logic                run,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic                prog_we,
   input  logic [RAM_AW-1:0]   prog_addr,
   input  logic [7:0]          prog_data,
   input  logic                view,
   output logic [7:0]          col,
   output logic [7:0]          row,
   output logic [7:0]          r6_out,
   output logic                c_flag,
   output logic                ie
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_OPER  = 2'd1;
   localparam logic [1:0] S_IRQ   = 2'd2;
   localparam int CW = $clog2(REP_DLY + 1);

   logic [7:0]          ram [2**RAM_AW];
   logic [7:0]          r   [8];
   logic [7:0]          vr  [8];
   logic [RAM_AW-1:0]   pc, lr, ilr;
   logic [7:0]          ir;
   logic [1:0]          state;
   logic [NUM_KEYS-1:0] k_s1, k_s2, k_prev, pend;
   logic [NUM_KEYS-1:0] key_ev, pend_clr, irq_oh;
   logic [CW-1:0]       cnt [NUM_KEYS];
   logic [SCAN_DIV-1:0] scan;
   logic [2:0]          idx;

   logic                step;
   logic [7:0]          cur, op, src;
   logic [RAM_AW-1:0]   a;
   logic [8:0]          sum;
   logic [3:0]          irq_k;
   logic                two_byte;

   logic [1:0]          st_nx;
   logic [RAM_AW-1:0]   pc_nx, lr_nx, ilr_nx;
   logic                c_nx, ie_nx;
   logic                ir_en, wr_en, vw_en, str_en;
   logic [2:0]          wr_idx;
   logic [7:0]          wr_val;

   // R5 is a read-only window onto the synchronised keys
   function automatic logic [7:0] rval(input logic [2:0] i);
      return (i == 3'd5) ? 8'(k_s2) : r[i];
   endfunction

   assign step   = step_en & run;
   assign cur    = ram[pc];
   assign op     = (state == S_FETCH) ? cur : ir;
   assign a      = cur[RAM_AW-1:0];
   assign src    = rval(op[2:0]);
   assign sum    = {1'b0, r[0]} + {1'b0, src};
   assign r6_out = r[6];

   assign two_byte = (cur == 8'hC0) || (cur == 8'hD0) ||
                     (cur == 8'hC2) || (cur[7:3] == 5'b11100) ||
                     (cur[7:4] == 4'b1111);

   // lowest pending key wins
   always_comb begin
      irq_k = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--)
         if (pend[k]) irq_k = 4'(k);
      irq_oh = NUM_KEYS'(1) << irq_k;
   end

   always_comb begin
      st_nx    = state;
      pc_nx    = pc;
      lr_nx    = lr;
      ilr_nx   = ilr;
      c_nx     = c_flag;
      ie_nx    = ie;
      ir_en    = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = op[2:0];
      wr_val   = 8'h00;
      vw_en    = 1'b0;
      str_en   = 1'b0;
      pend_clr = '0;
      if (step) begin
         case (state)
            S_FETCH: begin
               if (ie && |pend) begin
                  st_nx = S_IRQ;
               end else begin
                  ir_en = 1'b1;
                  pc_nx = pc + 1'b1;
                  if (two_byte) begin
                     st_nx = S_OPER;
                  end else begin
                     unique case (cur[7:6])
                        2'b00: begin
                           wr_en  = 1'b1;
                           wr_idx = cur[5:3];
                           wr_val = src;
                        end
                        2'b01: begin
                           wr_en = 1'b1;
                           unique case (cur[5:3])
                              3'd0: begin
                                 wr_idx = 3'd0;
                                 wr_val = sum[7:0];
                                 c_nx   = sum[8];
                              end
                              3'd1: begin
                                 wr_idx = 3'd0;
                                 wr_val = r[0] | src;
                              end
                              3'd2: begin
                                 wr_idx = 3'd0;
                                 wr_val = r[0] & src;
                              end
                              3'd3: begin
                                 wr_idx = 3'd0;
                                 wr_val = r[0] ^ src;
                              end
                              3'd4: begin
                                 wr_val = src + 8'd1;
                                 c_nx   = (src == 8'hFF);
                              end
                              3'd5: wr_val = ~src;
                              3'd6: wr_val = {src[0], src[7:1]};
                              default: wr_val = {src[6:0], src[7]};
                           endcase
                        end
                        2'b10: vw_en = 1'b1;
                        default: begin
                           case (cur)
                              8'hC3: pc_nx = lr;
                              8'hC4: begin
                                 pc_nx = ilr;
                                 ie_nx = 1'b1;
                              end
                              8'hC1: ie_nx = 1'b0;
                              8'hD1: ie_nx = 1'b1;
                              default: ;
                           endcase
                        end
                     endcase
                  end
               end
            end
            S_OPER: begin
               pc_nx = pc + 1'b1;
               st_nx = S_FETCH;
               unique case (1'b1)
                  (ir[7:3] == 5'b11100): begin
                     wr_en  = 1'b1;
                     wr_val = cur;
                  end
                  (ir[7:3] == 5'b11110): begin
                     wr_en  = 1'b1;
                     wr_val = ram[a];
                  end
                  (ir[7:3] == 5'b11111): str_en = 1'b1;
                  (ir == 8'hC0): begin
                     if (!c_flag) pc_nx = a;
                     c_nx = 1'b0;
                  end
                  (ir == 8'hD0): pc_nx = a;
                  (ir == 8'hC2): begin
                     lr_nx = pc + 1'b1;
                     pc_nx = a;
                  end
                  default: ;
               endcase
            end
            S_IRQ: begin
               ilr_nx   = pc;
               pc_nx    = RAM_AW'(5'd2 + {irq_k, 1'b0});
               ie_nx    = 1'b0;
               pend_clr = irq_oh;
               st_nx    = S_FETCH;
            end
            default: st_nx = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_FETCH;
         pc     <= '0;
         lr     <= '0;
         ilr    <= '0;
         ir     <= '0;
         c_flag <= 1'b0;
         ie     <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r[i]  <= '0;
            vr[i] <= '0;
         end
      end else begin
         state  <= st_nx;
         pc     <= pc_nx;
         lr     <= lr_nx;
         ilr    <= ilr_nx;
         c_flag <= c_nx;
         ie     <= ie_nx;
         if (ir_en) ir <= cur;
         if (wr_en && wr_idx != 3'd5) r[wr_idx] <= wr_val;
         if (vw_en) vr[op[5:3]] <= src;
      end
   end

   // external loader has priority over a same-cycle STR
   always_ff @(posedge clk) begin
      if (prog_we) ram[prog_addr] <= prog_data;
      else if (str_en) ram[a] <= src;
   end

   // repeat fires when the counter reaches REP_DLY, then reloads
   // so the next one lands REP_RATE ticks later
   always_comb begin
      key_ev = '0;
      for (int k = 0; k < NUM_KEYS; k++)
         key_ev[k] = k_s2[k] & (~k_prev[k] |
                     (step_en & (cnt[k] == CW'(REP_DLY - 1))));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_s1   <= '0;
         k_s2   <= '0;
         k_prev <= '0;
         pend   <= '0;
         for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
      end else begin
         k_s1   <= key_in;
         k_s2   <= k_s1;
         k_prev <= k_s2;
         pend   <= (pend & ~pend_clr) | key_ev;
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (!k_s2[k])
               cnt[k] <= '0;
            else if (step_en) begin
               if (cnt[k] == CW'(REP_DLY - 1))
                  cnt[k] <= CW'(REP_DLY - REP_RATE);
               else
                  cnt[k] <= cnt[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) scan <= '0;
      else     scan <= scan + 1'b1;
   end

   assign idx = scan[SCAN_DIV-1 -: 3];
   assign row = ~(8'b1 << idx);
   assign col = view ? rval(idx) : vr[idx];

endmodule

// File: tb/tb_matrix_cpu_core.sv
// tb_matrix_cpu_core: directed table-driven checks of matrix_cpu_core
// plus hand-written sequences for jumps, calls, IRQs, repeat and scan.
module tb_matrix_cpu_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step_en = 1'b0;
   logic       run = 1'b1;
   logic [5:0] key_in = '0;
   logic       prog_we = 1'b0;
   logic [7:0] prog_addr = '0;
   logic [7:0] prog_data = '0;
   logic       view = 1'b0;
   logic [7:0] col, row, r6_out;
   logic       c_flag, ie;

   int checks = 0;
   int errors = 0;
   int tick = 0;
   logic mon = 1'b0;
   int ev_log[$];

   matrix_cpu_core #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .step_en(step_en), .run(run),
      .key_in(key_in), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .view(view), .col(col), .row(row),
      .r6_out(r6_out), .c_flag(c_flag), .ie(ie)
   );

   always #5 clk = ~clk;

   always begin
      @(negedge clk);
      #2;
      if (mon && dut.key_ev[0]) ev_log.push_back(tick);
   end

   typedef struct {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] where;
      logic [2:0] idx;
      logic [7:0] exp;
      logic       c;
   } vec_t;

   vec_t tv [14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      step_en = 1'b0;
      run = 1'b1;
      key_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wr(input int ad, input logic [7:0] d);
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = ad[7:0];
      prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic ldp(input int base, input logic [63:0] bytes,
                      input int n);
      for (int i = 0; i < n; i++)
         wr(base + i, bytes[8*(n-1-i) +: 8]);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step_en = 1'b1;
         @(negedge clk);
         step_en = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] got;

      tv[0]  = '{8'h42, 8'hF0, 8'h20, 2'd0, 3'd0, 8'h10, 1'b1};
      tv[1]  = '{8'h4A, 8'hF0, 8'h0F, 2'd0, 3'd0, 8'hFF, 1'b0};
      tv[2]  = '{8'h52, 8'hF0, 8'h3C, 2'd0, 3'd0, 8'h30, 1'b0};
      tv[3]  = '{8'h5A, 8'hF0, 8'hFF, 2'd0, 3'd0, 8'h0F, 1'b0};
      tv[4]  = '{8'h62, 8'h00, 8'hFF, 2'd0, 3'd2, 8'h00, 1'b1};
      tv[5]  = '{8'h62, 8'h00, 8'h7F, 2'd0, 3'd2, 8'h80, 1'b0};
      tv[6]  = '{8'h6A, 8'h00, 8'h5A, 2'd0, 3'd2, 8'hA5, 1'b0};
      tv[7]  = '{8'h72, 8'h00, 8'h81, 2'd0, 3'd2, 8'hC0, 1'b0};
      tv[8]  = '{8'h7A, 8'h00, 8'h81, 2'd0, 3'd2, 8'h03, 1'b0};
      tv[9]  = '{8'h22, 8'h00, 8'h3C, 2'd0, 3'd4, 8'h3C, 1'b0};
      tv[10] = '{8'h2A, 8'h00, 8'h3C, 2'd0, 3'd5, 8'h00, 1'b0};
      tv[11] = '{8'h32, 8'h00, 8'h3C, 2'd2, 3'd6, 8'h3C, 1'b0};
      tv[12] = '{8'h9A, 8'h00, 8'h3C, 2'd1, 3'd3, 8'h3C, 1'b0};
      tv[13] = '{8'hE8, 8'h11, 8'h22, 2'd0, 3'd0, 8'h11, 1'b0};

      // reset state, sampled while rst is held
      @(negedge clk);
      @(negedge clk);
      chk("rst_row", 32'(row), 32'hFE);
      chk("rst_col", 32'(col), 32'h00);
      chk("rst_r6", 32'(r6_out), 32'h00);
      chk("rst_c", 32'(c_flag), 32'h0);
      chk("rst_ie", 32'(ie), 32'h0);
      chk("rst_pc", 32'(dut.pc), 32'h0);

      // single-instruction vectors: MVI R0,a; MVI R2,b; op
      for (int i = 0; i < 14; i++) begin
         do_reset();
         ldp(0, {24'h0, 8'hE0, tv[i].a, 8'hE2, tv[i].b, tv[i].op}, 5);
         step(5);
         case (tv[i].where)
            2'd0: got = dut.r[tv[i].idx];
            2'd1: got = dut.vr[tv[i].idx];
            default: got = r6_out;
         endcase
         chk($sformatf("vec%0d_res", i), 32'(got), 32'(tv[i].exp));
         chk($sformatf("vec%0d_c", i), 32'(c_flag), 32'(tv[i].c));
         chk($sformatf("vec%0d_pc", i), 32'(dut.pc), 32'd5);
      end

      // ADD carry then JNC fall-through / taken
      do_reset();
      ldp(0, 64'h00_00_00_E0_F0_E1_20_41, 5);
      ldp(5, 64'hC0_00_C0_0A, 4);
      step(5);
      chk("add_r0", 32'(dut.r[0]), 32'h10);
      chk("add_c", 32'(c_flag), 32'h1);
      step(2);
      chk("jnc_fall_pc", 32'(dut.pc), 32'd7);
      chk("jnc_fall_c", 32'(c_flag), 32'h0);
      step(2);
      chk("jnc_take_pc", 32'(dut.pc), 32'h0A);

      // STR / LD round trip, then loader beats STR
      do_reset();
      ldp(0, 64'hE0_5A_F8_28_F3_28_F8_29, 8);
      step(6);
      chk("str_ram40", 32'(dut.ram[40]), 32'h5A);
      chk("ld_r3", 32'(dut.r[3]), 32'h5A);
      step(1);
      @(negedge clk);
      step_en = 1'b1;
      prog_we = 1'b1;
      prog_addr = 8'd41;
      prog_data = 8'h77;
      @(negedge clk);
      step_en = 1'b0;
      prog_we = 1'b0;
      chk("we_prio_ram41", 32'(dut.ram[41]), 32'h77);
      chk("we_prio_pc", 32'(dut.pc), 32'd8);

      // CALL 30 / RET
      do_reset();
      ldp(0, 64'hC2_1E, 2);
      wr(30, 8'hC3);
      step(2);
      chk("call_pc", 32'(dut.pc), 32'd30);
      chk("call_lr", 32'(dut.lr), 32'd2);
      step(1);
      chk("ret_pc", 32'(dut.pc), 32'd2);

      // two keys at once: lowest first, other kept
      do_reset();
      ldp(0, 64'hD1_D0_20, 3);
      wr(4, 8'hC4);
      wr(8, 8'hC4);
      ldp(32, 64'hD0_20, 2);
      step(1);
      chk("ei_ie", 32'(ie), 32'h1);
      step(2);
      chk("loop_pc", 32'(dut.pc), 32'd32);
      @(negedge clk);
      key_in = 6'b001010;
      repeat (4) @(negedge clk);
      chk("irq_pend", 32'(dut.pend), 32'b001010);
      step(2);
      chk("irq1_pc", 32'(dut.pc), 32'd4);
      chk("irq1_ie", 32'(ie), 32'h0);
      chk("irq1_pend", 32'(dut.pend), 32'b001000);
      chk("irq1_ilr", 32'(dut.ilr), 32'd32);
      step(1);
      chk("reti_pc", 32'(dut.pc), 32'd32);
      chk("reti_ie", 32'(ie), 32'h1);
      step(2);
      chk("irq3_pc", 32'(dut.pc), 32'd8);
      chk("irq3_pend", 32'(dut.pend), 32'b000000);

      // auto-repeat on key0 with the CPU frozen
      do_reset();
      ldp(0, 64'hD0_00, 2);
      run = 1'b0;
      tick = 0;
      mon = 1'b1;
      @(negedge clk);
      key_in = 6'b000001;
      repeat (3) @(negedge clk);
      for (int t = 1; t <= 40; t++) begin
         tick = t;
         step(1);
      end
      mon = 1'b0;
      chk("rep_count", 32'(ev_log.size()), 32'd4);
      if (ev_log.size() == 4) begin
         chk("rep_ev0", 32'(ev_log[0]), 32'd0);
         chk("rep_ev1", 32'(ev_log[1]), 32'd24);
         chk("rep_ev2", 32'(ev_log[2]), 32'd32);
         chk("rep_ev3", 32'(ev_log[3]), 32'd40);
      end
      chk("rep_pend", 32'(dut.pend), 32'b000001);
      chk("rep_frozen_pc", 32'(dut.pc), 32'd0);
      key_in = '0;
      repeat (4) @(negedge clk);
      chk("rep_cnt_clr", 32'(dut.cnt[0]), 32'd0);

      // run=0 mid-OPER holds, then VPOKE and scan
      do_reset();
      ldp(0, 64'hE1_A5_91, 3);
      step(1);
      run = 1'b0;
      step(3);
      chk("hold_pc", 32'(dut.pc), 32'd1);
      chk("hold_state", 32'(dut.state), 32'd1);
      run = 1'b1;
      step(2);
      chk("resume_r1", 32'(dut.r[1]), 32'hA5);
      chk("vpoke_vr2", 32'(dut.vr[2]), 32'hA5);
      view = 1'b0;
      for (int i = 0; i < 64 && row != 8'hFB; i++) @(negedge clk);
      chk("scan_row2", 32'(row), 32'hFB);
      chk("scan_col_vr2", 32'(col), 32'hA5);
      view = 1'b1;
      for (int i = 0; i < 64 && row != 8'hFD; i++) @(negedge clk);
      chk("scan_row1", 32'(row), 32'hFD);
      chk("scan_col_r1", 32'(col), 32'hA5);
      view = 1'b0;

      // reset mid-OPER abandons the instruction
      do_reset();
      step(1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_pc", 32'(dut.pc), 32'd0);
      chk("midrst_state", 32'(dut.state), 32'd0);
      step(1);
      chk("midrst_fetch_ir", 32'(dut.ir), 32'hE1);
      chk("midrst_fetch_pc", 32'(dut.pc), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
